fp_stream_accumulator: RTL
==========================

Name: fp_stream_accumulator

Overview:
- Sequential front-end for the team's combinational float32 adder. It sums a stream of LENGTH IEEE-754 single-precision values into one result.
- Drives the adder operands `add_a`/`add_b` from registers and captures `add_result` into its accumulator.
- Sits between the data source (e.g. the multiplier array) and the result consumer. Used for dot-product / neuron sums.

Parameters:
- LEN_WIDTH, 8, width of the element-count input; max stream length is 2^LEN_WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin a new sum; sampled only in IDLE
- length  in  LEN_WIDTH  number of elements in the stream; sampled with start
- in_data  in  32  float32 element
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- add_a  out  32  adder operand A = accumulator register
- add_b  out  32  adder operand B = registered element
- add_result  in  32  adder output (combinational from add_a/add_b)
- sum  out  32  final sum; held until the next start
- sum_valid  out  1  one-cycle pulse when sum is updated
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; acc, op_reg, sum=32'h0; op_valid, sum_valid, in_ready=0; remaining=0.
- States: IDLE, ACCUM, DRAIN, DONE.
- Accept rule: an element is accepted on a cycle where in_valid && in_ready.
- IDLE:
  - start=1 and length!=0: acc<=0, remaining<=length, go to ACCUM.
  - start=1 and length=0: go to DONE; sum becomes 0.
  - start=0: stay.
- ACCUM:
  - in_ready=1 while remaining!=0.
  - On accept: op_reg<=in_data, op_valid<=1, remaining<=remaining-1. Otherwise op_valid<=0.
  - The accept that makes remaining 0 moves the state to DRAIN, and in_ready drops the following cycle.
- acc update (any state): every cycle with op_valid=1, acc<=add_result. add_a=acc and add_b=op_reg are register outputs.
- DRAIN: in_ready=0; the final op_reg is folded into acc; op_valid<=0; go to DONE.
- DONE: sum<=acc (0 for length=0), sum_valid=1 for exactly this cycle, go to IDLE.
- Latency:
  - Last element accepted at cycle t → sum_valid=1 at cycle t+2.
  - start with length=0 → sum_valid on the next cycle.
- Throughput: one element per cycle sustained; gaps in in_valid only stall the count.
- start outside IDLE is ignored, with no effect on the ongoing sum.
- in_data is ignored while in_ready=0.
- No special handling for NaN/Inf/denormal; the block forwards add_result bit-exactly.
- busy=1 in ACCUM, DRAIN, DONE.
- reset mid-stream aborts immediately to the reset state; no sum_valid is produced for the aborted stream.

Test Plan:
- start, length=4; stream 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on back-to-back cycles → acc steps through 0x3F800000, 0x40400000, 0x40C00000, 0x41200000; sum=0x41200000 with a one-cycle sum_valid 2 cycles after the last accept.
- Same stream with in_valid low for 3 cycles between elements 2 and 3 → same sum 0x41200000; in_ready stays high through the gap; exactly 4 accepts.
- start with length=0 → sum=0x00000000 and sum_valid the next cycle; in_ready never asserts.
- start pulsed again mid-stream with length=1 → ignored; original length=4 sum completes correctly.
- reset asserted after 2 accepts → all outputs 0 asynchronously, state IDLE. A following length=1 run with 0x40A00000 yields sum=0x40A00000.
- in_valid held high for 6 values with length=3 → only the first 3 accepted; in_ready=0 from the cycle after the 3rd accept; busy drops the cycle after sum_valid.

Source files
------------

// File: rtl/fp_stream_accumulator.sv
// Sequential front-end for a combinational float32 adder: sums a stream of
// `length` single-precision elements into one result, one element per cycle.
module fp_stream_accumulator #(
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_result,
  output logic [31:0]          sum,
  output logic                 sum_valid,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [31:0]          op_q, op_d;
  logic                 op_valid_q, op_valid_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [31:0]          sum_q, sum_d;
  logic                 sum_valid_q, sum_valid_d;
  logic                 accept;

  assign in_ready  = (state_q == ACCUM) && (rem_q != '0);
  assign accept    = in_valid && in_ready;
  assign add_a     = acc_q;
  assign add_b     = op_q;
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    op_valid_d  = 1'b0;
    rem_d       = rem_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;

    if (op_valid_q) acc_d = add_result;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            acc_d   = '0;
            rem_d   = length;
            state_d = ACCUM;
          end else begin
            sum_d       = '0;
            sum_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          op_d       = in_data;
          op_valid_d = 1'b1;
          rem_d      = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Sum is captured from the final fold here so it is already stable
        // during the single DONE cycle in which sum_valid is high.
        sum_d       = op_valid_q ? add_result : acc_q;
        sum_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      op_valid_q  <= 1'b0;
      rem_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      op_valid_q  <= op_valid_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

endmodule
